// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: 11-bit frames in, {brk,ext,code} key codes out.
// Define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry output queue (default: one holding register).
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    ck_s, dt_s;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic          flt_done, strobe, bit_in;

  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] toc_q, toc_d;
  logic          timeout, done, bad;

  logic          ext_q, brk_q;
  logic          is_e0, is_f0, emit;
  logic [9:0]    code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
    end
  end

  assign flt_done = (fcnt == FW'(FILTER_LEN - 1));
  assign strobe   = fclk & ~ck_s[1] & flt_done;
  assign bit_in   = dt_s[1];

  // Level flips only once the synced clock has disagreed for FILTER_LEN samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else if (ck_s[1] == fclk) begin
      fcnt <= '0;
    end else if (flt_done) begin
      fclk <= ck_s[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign timeout = (state_q != IDLE) && (toc_q == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    toc_d   = '0;
    done    = 1'b0;
    bad     = 1'b0;
    if (state_q != IDLE && !strobe && toc_q != TW'(TIMEOUT_CYC))
      toc_d = toc_q + TW'(1);
    unique case (state_q)
      IDLE: if (strobe && !bit_in) begin
        state_d = DATA;
        bcnt_d  = '0;
      end
      DATA: if (strobe) begin
        sh_d   = {bit_in, sh_q[7:1]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        par_d   = bit_in;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if (bit_in && ^{sh_q, par_q}) done = 1'b1;
        else bad = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      bcnt_d  = '0;
      toc_d   = '0;
      bad     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      toc_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      toc_q   <= toc_d;
    end
  end

  assign is_e0 = (sh_q == 8'hE0);
  assign is_f0 = (sh_q == 8'hF0);
  assign emit  = done & ~is_e0 & ~is_f0;
  assign code  = {brk_q, ext_q, sh_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad;
      if (bad || emit) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (done) begin
        ext_q <= ext_q | is_e0;
        brk_q <= brk_q | is_f0;
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic        empty, full, pop, push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = ~empty & data_ack;
  assign push  = emit & (~full | pop);

  assign data_valid = ~empty;
  assign data       = empty ? 10'd0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= emit & ~push;
      if (pop)  rp <= rp + (AW+1)'(1);
      if (push) wp <= wp + (AW+1)'(1);
    end
  end
`else
  logic [9:0] data_q;
  logic       valid_q;

  assign data       = data_q;
  assign data_valid = valid_q;

  // An ack in the same cycle frees the slot, so the new code replaces the old.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (emit && (!valid_q || data_ack)) begin
        data_q  <= code;
        valid_q <= 1'b1;
      end else begin
        if (emit) overflow <= 1'b1;
        if (valid_q && data_ack) valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule
